// File: rtl/plru_alloc_ctrl.sv
// Allocation controller for a fully-associative structure: per-entry valid bits,
// tree-PLRU replacement and a refill request/grant/commit handshake.
module plru_alloc_ctrl #(
  parameter int ENTRIES = 8,
  parameter int IDX_W   = $clog2(ENTRIES)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               flush_i,
  input  logic               inval_i,
  input  logic [IDX_W-1:0]   inval_idx_i,
  input  logic               hit_i,
  input  logic [IDX_W-1:0]   hit_idx_i,
  input  logic               alloc_req_i,
  output logic               alloc_gnt_o,
  output logic [IDX_W-1:0]   alloc_idx_o,
  input  logic               alloc_commit_i,
  input  logic               alloc_abort_i,
  output logic [ENTRIES-1:0] valid_o,
  output logic               full_o
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t             state_q, state_n;
  logic [ENTRIES-1:0] valid_q, valid_n;
  logic [ENTRIES-2:0] tree_q, tree_n;
  logic [IDX_W-1:0]   idx_q, idx_n;
  logic [IDX_W-1:0]   plru_victim;
  logic [IDX_W-1:0]   free_victim;
  logic               any_free;
  logic [IDX_W-1:0]   victim;

  // Point every node on the path of entry i away from i.
  function automatic logic [ENTRIES-2:0] touch(input logic [ENTRIES-2:0] t,
                                               input logic [IDX_W-1:0] i);
    int k;
    k = 0;
    for (int d = IDX_W - 1; d >= 0; d--) begin
      t[k] = ~i[d];
      k = 2 * k + 1 + (i[d] ? 1 : 0);
    end
    return t;
  endfunction

  always_comb begin
    int k;
    plru_victim = '0;
    k = 0;
    for (int d = IDX_W - 1; d >= 0; d--) begin
      plru_victim[d] = tree_q[k];
      k = 2 * k + 1 + (tree_q[k] ? 1 : 0);
    end
  end

  always_comb begin
    free_victim = '0;
    any_free    = 1'b0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        free_victim = IDX_W'(i);
        any_free    = 1'b1;
      end
    end
  end

  assign victim = any_free ? free_victim : plru_victim;

  // Hit touch first, commit touch after it, flush last so it overrides all.
  always_comb begin
    state_n = state_q;
    valid_n = valid_q;
    tree_n  = tree_q;
    idx_n   = idx_q;

    if (hit_i && valid_q[hit_idx_i])
      tree_n = touch(tree_n, hit_idx_i);
    if (inval_i)
      valid_n[inval_idx_i] = 1'b0;

    case (state_q)
      IDLE: begin
        if (alloc_req_i) begin
          idx_n   = victim;
          state_n = GRANT;
        end
      end
      GRANT: begin
        if (alloc_commit_i) begin
          valid_n[idx_q] = 1'b1;
          tree_n         = touch(tree_n, idx_q);
          state_n        = IDLE;
        end else if (alloc_abort_i) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase

    if (flush_i) begin
      valid_n = '0;
      tree_n  = '0;
      state_n = IDLE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      valid_q <= '0;
      tree_q  <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_n;
      valid_q <= valid_n;
      tree_q  <= tree_n;
      idx_q   <= idx_n;
    end
  end

  assign alloc_gnt_o = (state_q == GRANT);
  assign alloc_idx_o = (state_q == GRANT) ? idx_q : '0;
  assign valid_o     = valid_q;
  assign full_o      = &valid_q;

endmodule

// File: tb/tb_plru_alloc_ctrl.sv
// Self-checking bench for plru_alloc_ctrl: directed scenarios plus random traffic,
// checked every cycle against an array-based PLRU/valid model.
module tb_plru_alloc_ctrl;
  localparam int N  = 8;
  localparam int LW = 3;

  logic         clk_i = 0;
  logic         rst_i = 0;
  logic         flush_i = 0, inval_i = 0, hit_i = 0;
  logic [LW-1:0] inval_idx_i = 0, hit_idx_i = 0;
  logic         alloc_req_i = 0, alloc_commit_i = 0, alloc_abort_i = 0;
  logic         alloc_gnt_o;
  logic [LW-1:0] alloc_idx_o;
  logic [N-1:0] valid_o;
  logic         full_o;

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 0;

  bit m_valid [N];
  bit m_node  [N-1];
  bit m_gnt;
  int m_idx;

  plru_alloc_ctrl #(.ENTRIES(N)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
    .inval_i(inval_i), .inval_idx_i(inval_idx_i),
    .hit_i(hit_i), .hit_idx_i(hit_idx_i),
    .alloc_req_i(alloc_req_i), .alloc_gnt_o(alloc_gnt_o), .alloc_idx_o(alloc_idx_o),
    .alloc_commit_i(alloc_commit_i), .alloc_abort_i(alloc_abort_i),
    .valid_o(valid_o), .full_o(full_o)
  );

  always #5 clk_i = ~clk_i;

  // Node for level l on entry i's path is (2^l - 1) + (i >> (LW - l)).
  function automatic void m_touch(int i);
    for (int l = 0; l < LW; l++) begin
      int n;
      n = (1 << l) - 1 + (i >> (LW - l));
      m_node[n] = ((i >> (LW - 1 - l)) & 1) ? 1'b0 : 1'b1;
    end
  endfunction

  function automatic int m_victim();
    int p;
    for (int i = 0; i < N; i++) if (!m_valid[i]) return i;
    p = 0;
    for (int l = 0; l < LW; l++) p = p * 2 + int'(m_node[(1 << l) - 1 + p]);
    return p;
  endfunction

  function automatic logic [N-1:0] m_valid_vec();
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = m_valid[i];
    return v;
  endfunction

  always @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      for (int i = 0; i < N; i++) m_valid[i] = 0;
      for (int i = 0; i < N - 1; i++) m_node[i] = 0;
      m_gnt = 0;
      if (rst_i) m_idx = 0;
    end else begin
      int v;
      v = m_victim();
      if (hit_i && m_valid[hit_idx_i]) m_touch(int'(hit_idx_i));
      if (inval_i) m_valid[inval_idx_i] = 0;
      if (!m_gnt) begin
        if (alloc_req_i) begin
          m_idx = v;
          m_gnt = 1;
        end
      end else if (alloc_commit_i) begin
        m_valid[m_idx] = 1;
        m_touch(m_idx);
        m_gnt = 0;
      end else if (alloc_abort_i) begin
        m_gnt = 0;
      end
    end
  end

  always @(negedge clk_i) begin
    if (chk_en) begin
      logic [N-1:0] ev;
      logic [LW-1:0] ei;
      ev = m_valid_vec();
      ei = m_gnt ? LW'(m_idx) : '0;
      vectors++;
      if (alloc_gnt_o !== m_gnt || alloc_idx_o !== ei || valid_o !== ev || full_o !== (&ev)) begin
        miscompares++;
        $display("FAIL model t=%0t gnt=%0b/%0b idx=%0d/%0d valid=%h/%h full=%0b/%0b (actual/required)",
                 $time, alloc_gnt_o, m_gnt, alloc_idx_o, ei, valid_o, ev, full_o, &ev);
      end
    end
  end

  task automatic tick();
    @(negedge clk_i);
    #1;
  endtask

  task automatic chk(string name, int act, int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic alloc_step(output int idx);
    alloc_req_i = 1; tick(); alloc_req_i = 0;
    chk("gnt_latency", int'(alloc_gnt_o), 1);
    idx = int'(alloc_idx_o);
  endtask

  initial begin
    int idx;
    #1;
    rst_i = 1; tick(); rst_i = 0;
    chk_en = 1;
    chk("reset_gnt", int'(alloc_gnt_o), 0);
    chk("reset_valid", int'(valid_o), 0);
    chk("reset_full", int'(full_o), 0);

    for (int i = 0; i < N; i++) begin
      alloc_step(idx);
      chk("fill_idx", idx, i);
      alloc_commit_i = 1; tick(); alloc_commit_i = 0;
    end
    chk("fill_full", int'(full_o), 1);
    chk("fill_valid", int'(valid_o), 255);

    alloc_step(idx); chk("plru_first", idx, 0);
    alloc_abort_i = 1; tick(); alloc_abort_i = 0;
    hit_i = 1; hit_idx_i = 0; tick(); hit_i = 0;
    alloc_step(idx); chk("plru_after_hit0", idx, 4);
    alloc_abort_i = 1; tick(); alloc_abort_i = 0;

    inval_i = 1; inval_idx_i = 5; tick(); inval_i = 0;
    chk("inval_full", int'(full_o), 0);
    alloc_step(idx); chk("inval_pref", idx, 5);
    chk("full_before_commit", int'(full_o), 0);
    alloc_commit_i = 1; tick(); alloc_commit_i = 0;
    chk("full_after_commit", int'(full_o), 1);

    inval_i = 1; inval_idx_i = 0; tick(); inval_i = 0;
    alloc_step(idx); chk("abort_idx", idx, 0);
    alloc_abort_i = 1; tick(); alloc_abort_i = 0;
    chk("abort_valid0", int'(valid_o[0]), 0);
    alloc_step(idx); chk("abort_again", idx, 0);
    alloc_commit_i = 1; alloc_abort_i = 1; tick(); alloc_commit_i = 0; alloc_abort_i = 0;
    chk("commit_beats_abort", int'(valid_o[0]), 1);
    inval_i = 1; inval_idx_i = 0; tick(); inval_i = 0;
    alloc_step(idx);
    alloc_commit_i = 1; inval_i = 1; inval_idx_i = 0; tick();
    alloc_commit_i = 0; inval_i = 0;
    chk("commit_beats_inval", int'(valid_o[0]), 1);

    alloc_step(idx);
    flush_i = 1; alloc_commit_i = 1; tick(); flush_i = 0; alloc_commit_i = 0;
    chk("flush_gnt", int'(alloc_gnt_o), 0);
    chk("flush_valid", int'(valid_o), 0);
    chk("flush_full", int'(full_o), 0);
    alloc_step(idx); chk("flush_next", idx, 0);
    alloc_commit_i = 1; tick(); alloc_commit_i = 0;

    for (int i = 1; i < N; i++) begin
      alloc_step(idx);
      alloc_commit_i = 1; tick(); alloc_commit_i = 0;
    end
    inval_i = 1; inval_idx_i = 2; tick(); inval_i = 0;
    alloc_step(idx); chk("hitcommit_idx", idx, 2);
    hit_i = 1; hit_idx_i = 7; alloc_commit_i = 1; tick(); hit_i = 0; alloc_commit_i = 0;
    alloc_step(idx); chk("hitcommit_victim", idx, 4);
    alloc_abort_i = 1; tick(); alloc_abort_i = 0;

    inval_i = 1; inval_idx_i = 3; tick(); inval_i = 0;
    alloc_step(idx);
    rst_i = 1; alloc_commit_i = 1; tick(); rst_i = 0; alloc_commit_i = 0;
    chk("rst_gnt", int'(alloc_gnt_o), 0);
    chk("rst_valid", int'(valid_o), 0);

    for (int c = 0; c < 4000; c++) begin
      alloc_req_i    = ($urandom_range(0, 99) < 40);
      alloc_commit_i = ($urandom_range(0, 99) < 45);
      alloc_abort_i  = ($urandom_range(0, 99) < 20);
      hit_i          = ($urandom_range(0, 99) < 50);
      hit_idx_i      = LW'($urandom_range(0, N - 1));
      inval_i        = ($urandom_range(0, 99) < 15);
      inval_idx_i    = LW'($urandom_range(0, N - 1));
      flush_i        = ($urandom_range(0, 299) == 0);
      rst_i          = ($urandom_range(0, 499) == 0);
      tick();
    end
    {alloc_req_i, alloc_commit_i, alloc_abort_i, hit_i, inval_i, flush_i, rst_i} = '0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/plru_alloc_ctrl.md
Name: plru_alloc_ctrl

Overview:
- Allocation controller for a fully-associative structure such as a TLB or PTW cache.
- Owns the per-entry valid bits and a tree-PLRU state, and arbitrates between hit updates, invalidations, flushes and a refill-allocation handshake.
- Picks the victim (invalid entry first, else PLRU), holds it stable while the refill writes, and updates replacement state on commit.
- Sits between the lookup/refill logic and the entry storage.

Parameters:
- ENTRIES, 8, number of entries; power of two, at least 2.
- IDX_W, $clog2(ENTRIES), index width; derived, not to be overridden.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous reset, active-high
- flush_i  in  1  invalidate all entries and reset the PLRU tree
- inval_i  in  1  invalidate a single entry
- inval_idx_i  in  IDX_W  entry to invalidate
- hit_i  in  1  lookup hit; touch the entry
- hit_idx_i  in  IDX_W  entry that hit
- alloc_req_i  in  1  refill requests an entry
- alloc_gnt_o  out  1  victim granted and held
- alloc_idx_o  out  IDX_W  granted victim index
- alloc_commit_i  in  1  refill written; mark valid and touch
- alloc_abort_i  in  1  refill cancelled
- valid_o  out  ENTRIES  per-entry valid bits
- full_o  out  1  all entries valid

Behaviour:
- Reset (rst_i sampled high on a clk_i edge):
  - valid = 0, tree = 0, FSM = IDLE.
  - alloc_gnt_o = 0, alloc_idx_o = 0, full_o = 0.
- Tree layout:
  - ENTRIES-1 node bits; node k has children 2k+1 and 2k+2; leaves map to entries in ascending order.
  - Node bit 0 means the victim is in the left (lower-index) half; 1 means the right half.
  - Touching entry i sets every node on i's path to point away from i.
  - The PLRU victim is found by following the node bits from the root.
- Victim selection (combinational on registered state):
  - If any entry is invalid, the victim is the lowest-index invalid entry.
  - Otherwise the victim is the PLRU victim.
- FSM IDLE:
  - alloc_req_i & !flush_i latches the victim into an index register; next state is GRANT.
  - Request-to-grant latency is 1 cycle.
- FSM GRANT:
  - alloc_gnt_o = 1 and alloc_idx_o holds the latched index; it is stable regardless of hits or invalidations.
  - alloc_req_i is ignored.
  - alloc_commit_i: set valid[idx], touch idx, go to IDLE.
  - alloc_abort_i alone: go to IDLE with no state change.
  - commit and abort in the same cycle: commit wins.
  - Minimum spacing is one allocation per 2 cycles.
- Outside GRANT: alloc_gnt_o = 0 and alloc_idx_o = 0.
- hit_i:
  - Touches hit_idx_i only if valid[hit_idx_i] = 1; otherwise it is ignored.
  - Hits are accepted in every state.
- inval_i: clears valid[inval_idx_i] and leaves the tree unchanged.
- Same-cycle priority, lowest to highest:
  - Hit touch is applied first; a commit touch is applied after it, so commit values win on shared nodes.
  - Invalidate vs commit on the same index: commit wins, entry ends valid. Different indices: both take effect.
  - flush_i overrides everything: valid = 0, tree = 0, FSM = IDLE, alloc_gnt_o = 0 next cycle. A simultaneous commit is discarded.
- Registers and outputs:
  - All state registers update on the clk_i edge; outputs are registered state or simple decodes of it.
  - full_o = &valid.
  - valid_o and full_o reflect updates the cycle after the causing input.

Test Plan (ENTRIES=8):
- Fill: from reset, 8× (req, wait gnt, commit next cycle) -> grants idx 0,1,...,7 in order, each gnt 1 cycle after req; full_o = 1 the cycle after the 8th commit; valid_o = 8'hFF.
- PLRU after fill: alloc -> idx 0 (abort it); hit 0, then alloc -> idx 4.
- Invalidate preference: full, inval idx 5, then alloc -> idx 5; full_o = 0 until commit, then 1.
- Abort and conflict:
  - GRANT idx 0 with abort -> valid unchanged; next alloc -> idx 0 again.
  - commit+abort same cycle -> valid[0] = 1.
  - inval 0 + commit 0 same cycle -> valid[0] = 1.
- Flush mid-operation: GRANT with flush_i and alloc_commit_i high in the same cycle -> next cycle alloc_gnt_o = 0, valid_o = 0, full_o = 0; next alloc -> idx 0.
- Simultaneous hit/commit: full, GRANT idx 2, hit 7 + commit 2 same cycle -> root bit = 1 (victim side right); next alloc (all valid) victim in 4..7, specifically idx 4.
- Synchronous reset mid-GRANT: rst_i high one edge -> alloc_gnt_o = 0, valid_o = 0, no commit effect.
